// File: rtl/riscv_pkg.sv
// Shared RV32I core definitions.
// Fetch-stage state encoding and architectural constants.
package riscv_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [2:0] {
    BOOT,
    REQ,
    WAIT,
    HOLD,
    DRAIN
  } fetch_state_e;

endpackage

// File: rtl/pc_fetch_unit.sv
// PC register and single-outstanding instruction fetch.
// PC+4 comes from the external adder on pc_inc_i.
module pc_fetch_unit
  import riscv_pkg::*;
#(
  parameter int unsigned XLEN = riscv_pkg::XLEN,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic [XLEN-1:0] pc_o,
  input  logic [XLEN-1:0] pc_inc_i,
  input  logic            redirect_valid_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  input  logic            stall_i,
  output logic            imem_req_o,
  output logic [XLEN-1:0] imem_addr_o,
  input  logic            imem_gnt_i,
  input  logic            imem_rvalid_i,
  input  logic [31:0]     imem_rdata_i,
  output logic            instr_valid_o,
  output logic [31:0]     instr_o,
  output logic [XLEN-1:0] instr_pc_o,
  input  logic            instr_ready_i,
  output logic            misalign_o
);

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] ipc_q, ipc_d;
  logic [31:0]     instr_q, instr_d;
  logic            valid_q, valid_d;
  logic            mis_q, mis_d;
  logic [XLEN-1:0] redir_pc;

  assign redir_pc = {redirect_pc_i[XLEN-1:2], 2'b00};

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ipc_d   = ipc_q;
    instr_d = instr_q;
    valid_d = valid_q;
    mis_d   = 1'b0;
    unique case (state_q)
      BOOT: state_d = REQ;
      REQ: begin
        if (imem_gnt_i) state_d = WAIT;
      end
      WAIT: begin
        if (imem_rvalid_i) begin
          instr_d = imem_rdata_i;
          ipc_d   = pc_q;
          pc_d    = pc_inc_i;
          valid_d = 1'b1;
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (instr_ready_i && !stall_i) begin
          valid_d = 1'b0;
          state_d = REQ;
        end
      end
      DRAIN: begin
        if (imem_rvalid_i) state_d = REQ;
      end
      default: state_d = BOOT;
    endcase
    if (redirect_valid_i) begin
      pc_d    = redir_pc;
      ipc_d   = ipc_q;
      instr_d = instr_q;
      valid_d = 1'b0;
      mis_d   = |redirect_pc_i[1:0];
      // An in-flight grant must drain; data arriving now closes it.
      unique case (state_q)
        REQ:     state_d = imem_gnt_i ? DRAIN : REQ;
        WAIT:    state_d = imem_rvalid_i ? REQ : DRAIN;
        DRAIN:   state_d = imem_rvalid_i ? REQ : DRAIN;
        default: state_d = REQ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= BOOT;
      pc_q    <= RESET_VECTOR;
      ipc_q   <= '0;
      instr_q <= NOP_INSTR;
      valid_q <= 1'b0;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ipc_q   <= ipc_d;
      instr_q <= instr_d;
      valid_q <= valid_d;
      mis_q   <= mis_d;
    end
  end

  assign pc_o          = pc_q;
  assign imem_addr_o   = pc_q;
  assign imem_req_o    = (state_q == REQ);
  assign instr_valid_o = valid_q;
  assign instr_o       = instr_q;
  assign instr_pc_o    = ipc_q;
  assign misalign_o    = mis_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Bench for pc_fetch_unit: memory responder, external adder,
// directed scenarios and a randomized run against a PC-stream model.
module tb_pc_fetch_unit;

  logic        clk;
  logic        rst_n;
  logic [31:0] pc_o;
  logic [31:0] pc_inc_i;
  logic        redirect_valid_i;
  logic [31:0] redirect_pc_i;
  logic        stall_i;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_gnt_i;
  logic        imem_rvalid_i;
  logic [31:0] imem_rdata_i;
  logic        instr_valid_o;
  logic [31:0] instr_o;
  logic [31:0] instr_pc_o;
  logic        instr_ready_i;
  logic        misalign_o;

  int n_cmp = 0;
  int n_bad = 0;
  int gnt_delay = 0;
  int rv_lat = 0;
  logic [31:0] mem [logic [31:0]];

  pc_fetch_unit dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .pc_o             (pc_o),
    .pc_inc_i         (pc_inc_i),
    .redirect_valid_i (redirect_valid_i),
    .redirect_pc_i    (redirect_pc_i),
    .stall_i          (stall_i),
    .imem_req_o       (imem_req_o),
    .imem_addr_o      (imem_addr_o),
    .imem_gnt_i       (imem_gnt_i),
    .imem_rvalid_i    (imem_rvalid_i),
    .imem_rdata_i     (imem_rdata_i),
    .instr_valid_o    (instr_valid_o),
    .instr_o          (instr_o),
    .instr_pc_o       (instr_pc_o),
    .instr_ready_i    (instr_ready_i),
    .misalign_o       (misalign_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // external PC+4 adder
  assign pc_inc_i = pc_o + 32'd4;

  function automatic logic [31:0] word_at(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return {a[15:0], 16'h0013} ^ 32'h5A5A_0000;
  endfunction

  // memory: grant after gnt_delay ungranted cycles, data rv_lat later
  initial begin : responder
    bit          pend;
    int          gw;
    int          rw;
    logic [31:0] paddr;
    pend = 1'b0;
    gw = 0;
    rw = 0;
    paddr = '0;
    imem_gnt_i = 1'b0;
    imem_rvalid_i = 1'b0;
    imem_rdata_i = '0;
    forever begin
      @(negedge clk);
      imem_gnt_i = 1'b0;
      imem_rvalid_i = 1'b0;
      if (!rst_n) begin
        pend = 1'b0;
        gw = gnt_delay;
      end else if (pend) begin
        if (rw <= 0) begin
          imem_rvalid_i = 1'b1;
          imem_rdata_i = word_at(paddr);
          pend = 1'b0;
          gw = gnt_delay;
        end else rw--;
      end else if (imem_req_o) begin
        if (gw <= 0) begin
          imem_gnt_i = 1'b1;
          pend = 1'b1;
          paddr = imem_addr_o;
          rw = rv_lat;
        end else gw--;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic cyc();
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    redirect_valid_i = 1'b0;
    redirect_pc_i = '0;
    stall_i = 1'b0;
    instr_ready_i = 1'b0;
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic wait_valid(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i <= budget; i++) begin
      if (instr_valid_o) begin
        ok = 1'b1;
        break;
      end
      cyc();
    end
  endtask

  task automatic wait_req(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i <= budget; i++) begin
      if (imem_req_o) begin
        ok = 1'b1;
        break;
      end
      cyc();
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if (pc_o !== 32'h0) begin
      n_bad++;
      $display("FAIL reset_pc: got %h want %h", pc_o, 32'h0);
    end
    n_cmp++;
    if (imem_req_o !== 1'b0 || instr_valid_o !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_ctl: req=%b valid=%b want 0 0",
               imem_req_o, instr_valid_o);
    end
    n_cmp++;
    if (instr_o !== 32'h13) begin
      n_bad++;
      $display("FAIL reset_instr: got %h want %h", instr_o, 32'h13);
    end
    n_cmp++;
    if (instr_pc_o !== 32'h0 || misalign_o !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_ipc_mis: ipc=%h mis=%b want 0 0",
               instr_pc_o, misalign_o);
    end
  endtask

  task automatic test_first_fetch();
    int lat;
    bit seen;
    gnt_delay = 0;
    rv_lat = 0;
    mem[32'h0] = 32'h0000_0093;
    do_reset();
    instr_ready_i = 1'b1;
    lat = 0;
    seen = 1'b0;
    for (int i = 0; i < 10 && !instr_valid_o; i++) begin
      cyc();
      lat++;
      if (imem_req_o && !seen) begin
        seen = 1'b1;
        n_cmp++;
        if (imem_addr_o !== 32'h0) begin
          n_bad++;
          $display("FAIL ff_addr: got %h want 0", imem_addr_o);
        end
      end
    end
    n_cmp++;
    if (lat != 3) begin
      n_bad++;
      $display("FAIL ff_latency: got %0d want 3", lat);
    end
    n_cmp++;
    if (instr_o !== 32'h93 || instr_pc_o !== 32'h0) begin
      n_bad++;
      $display("FAIL ff_data: instr=%h ipc=%h want 00000093 0",
               instr_o, instr_pc_o);
    end
    n_cmp++;
    if (pc_o !== 32'h4) begin
      n_bad++;
      $display("FAIL ff_pc: got %h want 4", pc_o);
    end
    cyc();
    n_cmp++;
    if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h4) begin
      n_bad++;
      $display("FAIL ff_next_req: req=%b addr=%h want 1 4",
               imem_req_o, imem_addr_o);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] w [3];
    logic [31:0] prev_addr;
    bit          prev_ungr;
    bit          pv;
    int          k;
    w[0] = 32'h00A0_0093;
    w[1] = 32'h00B0_0113;
    w[2] = 32'h00C0_0193;
    for (int i = 0; i < 3; i++) mem[32'(i * 4)] = w[i];
    gnt_delay = 2;
    rv_lat = 0;
    do_reset();
    instr_ready_i = 1'b1;
    k = 0;
    pv = 1'b0;
    prev_ungr = 1'b0;
    prev_addr = '0;
    for (int i = 0; i < 80 && k < 3; i++) begin
      cyc();
      if (prev_ungr && imem_req_o) begin
        n_cmp++;
        if (imem_addr_o !== prev_addr) begin
          n_bad++;
          $display("FAIL b2b_addr_stable: got %h want %h",
                   imem_addr_o, prev_addr);
        end
      end
      prev_ungr = imem_req_o && !imem_gnt_i;
      prev_addr = imem_addr_o;
      if (instr_valid_o && !pv) begin
        n_cmp++;
        if (instr_pc_o !== 32'(k * 4) || instr_o !== w[k]) begin
          n_bad++;
          $display("FAIL b2b_deliver%0d: ipc=%h instr=%h want %h %h",
                   k, instr_pc_o, instr_o, 32'(k * 4), w[k]);
        end
        k++;
      end
      pv = instr_valid_o;
    end
    n_cmp++;
    if (k != 3) begin
      n_bad++;
      $display("FAIL b2b_count: got %0d want 3", k);
    end
  endtask

  task automatic test_stall();
    bit          ok;
    logic [31:0] saved;
    gnt_delay = 0;
    rv_lat = 1;
    do_reset();
    instr_ready_i = 1'b1;
    stall_i = 1'b1;
    wait_valid(20, ok);
    n_cmp++;
    if (!ok) begin
      n_bad++;
      $display("FAIL stall_wait: valid=%b want 1", instr_valid_o);
    end
    saved = instr_o;
    for (int i = 0; i < 3; i++) begin
      cyc();
      n_cmp++;
      if (instr_valid_o !== 1'b1 || instr_o !== saved ||
          imem_req_o !== 1'b0) begin
        n_bad++;
        $display("FAIL stall_hold%0d: v=%b instr=%h req=%b want 1 %h 0",
                 i, instr_valid_o, instr_o, imem_req_o, saved);
      end
    end
    stall_i = 1'b0;
    cyc();
    n_cmp++;
    if (imem_req_o !== 1'b1 || instr_valid_o !== 1'b0 ||
        imem_addr_o !== 32'h4) begin
      n_bad++;
      $display("FAIL stall_release: req=%b v=%b addr=%h want 1 0 4",
               imem_req_o, instr_valid_o, imem_addr_o);
    end
  endtask

  task automatic test_redirect_wait();
    bit ok;
    bit leak;
    bit mis_seen;
    bit seen;
    mem[32'h0] = 32'hDEAD_BEEF;
    mem[32'h100] = 32'h0010_0093;
    gnt_delay = 0;
    rv_lat = 3;
    do_reset();
    instr_ready_i = 1'b1;
    wait_req(10, ok);
    cyc();
    n_cmp++;
    if (!ok || imem_req_o !== 1'b0) begin
      n_bad++;
      $display("FAIL rw_in_wait: ok=%b req=%b want 1 0", ok, imem_req_o);
    end
    redirect_valid_i = 1'b1;
    redirect_pc_i = 32'h100;
    cyc();
    redirect_valid_i = 1'b0;
    n_cmp++;
    if (pc_o !== 32'h100 || instr_valid_o !== 1'b0) begin
      n_bad++;
      $display("FAIL rw_pc: pc=%h v=%b want 100 0", pc_o, instr_valid_o);
    end
    leak = 1'b0;
    mis_seen = misalign_o;
    seen = 1'b0;
    for (int i = 0; i < 20 && !instr_valid_o; i++) begin
      if (instr_o === 32'hDEAD_BEEF) leak = 1'b1;
      if (imem_req_o && !seen) begin
        seen = 1'b1;
        n_cmp++;
        if (imem_addr_o !== 32'h100) begin
          n_bad++;
          $display("FAIL rw_req_addr: got %h want 100", imem_addr_o);
        end
      end
      cyc();
      if (misalign_o) mis_seen = 1'b1;
    end
    n_cmp++;
    if (leak || instr_o !== 32'h0010_0093 || instr_pc_o !== 32'h100) begin
      n_bad++;
      $display("FAIL rw_deliver: leak=%b instr=%h ipc=%h want 0 00100093 100",
               leak, instr_o, instr_pc_o);
    end
    n_cmp++;
    if (mis_seen) begin
      n_bad++;
      $display("FAIL rw_misalign: got 1 want 0");
    end
  endtask

  task automatic test_redirect_hold();
    bit ok;
    gnt_delay = 0;
    rv_lat = 0;
    do_reset();
    wait_valid(20, ok);
    redirect_valid_i = 1'b1;
    redirect_pc_i = 32'h102;
    cyc();
    redirect_valid_i = 1'b0;
    n_cmp++;
    if (!ok || misalign_o !== 1'b1 || pc_o !== 32'h100 ||
        instr_valid_o !== 1'b0) begin
      n_bad++;
      $display("FAIL rh_edge: ok=%b mis=%b pc=%h v=%b want 1 1 100 0",
               ok, misalign_o, pc_o, instr_valid_o);
    end
    cyc();
    n_cmp++;
    if (misalign_o !== 1'b0) begin
      n_bad++;
      $display("FAIL rh_pulse: mis=%b want 0", misalign_o);
    end
  endtask

  task automatic test_wrap();
    bit ok;
    gnt_delay = 0;
    rv_lat = 0;
    do_reset();
    wait_valid(20, ok);
    redirect_valid_i = 1'b1;
    redirect_pc_i = 32'hFFFF_FFFC;
    cyc();
    redirect_valid_i = 1'b0;
    instr_ready_i = 1'b1;
    wait_valid(20, ok);
    n_cmp++;
    if (!ok || instr_pc_o !== 32'hFFFF_FFFC ||
        instr_o !== word_at(32'hFFFF_FFFC) || pc_o !== 32'h0) begin
      n_bad++;
      $display("FAIL wrap: ok=%b ipc=%h instr=%h pc=%h want 1 fffffffc %h 0",
               ok, instr_pc_o, instr_o, word_at(32'hFFFF_FFFC), pc_o);
    end
    cyc();
    n_cmp++;
    if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h0) begin
      n_bad++;
      $display("FAIL wrap_req: req=%b addr=%h want 1 0",
               imem_req_o, imem_addr_o);
    end
  endtask

  task automatic test_async_reset();
    bit ok;
    gnt_delay = 0;
    rv_lat = 4;
    do_reset();
    instr_ready_i = 1'b1;
    wait_valid(20, ok);
    cyc();
    cyc();
    n_cmp++;
    if (!ok || pc_o !== 32'h4 || imem_req_o !== 1'b0) begin
      n_bad++;
      $display("FAIL ar_setup: ok=%b pc=%h req=%b want 1 4 0",
               ok, pc_o, imem_req_o);
    end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if (pc_o !== 32'h0 || instr_o !== 32'h13 || instr_pc_o !== 32'h0) begin
      n_bad++;
      $display("FAIL ar_regs: pc=%h instr=%h ipc=%h want 0 13 0",
               pc_o, instr_o, instr_pc_o);
    end
    n_cmp++;
    if (instr_valid_o !== 1'b0 || imem_req_o !== 1'b0 ||
        misalign_o !== 1'b0) begin
      n_bad++;
      $display("FAIL ar_ctl: v=%b req=%b mis=%b want 0 0 0",
               instr_valid_o, imem_req_o, misalign_o);
    end
    @(negedge clk);
    #1 rst_n = 1'b1;
    wait_req(10, ok);
    n_cmp++;
    if (!ok || imem_addr_o !== 32'h0) begin
      n_bad++;
      $display("FAIL ar_restart: ok=%b addr=%h want 1 0", ok, imem_addr_o);
    end
    wait_valid(20, ok);
    n_cmp++;
    if (!ok || instr_pc_o !== 32'h0 || instr_o !== word_at(32'h0)) begin
      n_bad++;
      $display("FAIL ar_refetch: ok=%b ipc=%h instr=%h want 1 0 %h",
               ok, instr_pc_o, instr_o, word_at(32'h0));
    end
  endtask

  task automatic test_random();
    logic [31:0] exp_pc;
    logic [31:0] prev_instr;
    logic [31:0] tgt;
    bit          mis_exp;
    bit          pv;
    int          ndel;
    gnt_delay = 1;
    rv_lat = 1;
    do_reset();
    exp_pc = 32'h0;
    mis_exp = 1'b0;
    pv = 1'b0;
    prev_instr = instr_o;
    ndel = 0;
    for (int i = 0; i < 3000; i++) begin
      cyc();
      n_cmp++;
      if (misalign_o !== mis_exp || imem_addr_o !== pc_o) begin
        n_bad++;
        $display("FAIL rnd_mis_addr@%0d: mis=%b addr=%h want %b %h",
                 i, misalign_o, imem_addr_o, mis_exp, pc_o);
      end
      if (instr_valid_o && !pv) begin
        n_cmp++;
        if (instr_pc_o !== exp_pc || instr_o !== word_at(exp_pc)) begin
          n_bad++;
          $display("FAIL rnd_deliver@%0d: ipc=%h instr=%h want %h %h",
                   i, instr_pc_o, instr_o, exp_pc, word_at(exp_pc));
        end
        exp_pc = exp_pc + 32'd4;
        ndel++;
      end else if (instr_valid_o && pv) begin
        n_cmp++;
        if (instr_o !== prev_instr) begin
          n_bad++;
          $display("FAIL rnd_hold@%0d: instr=%h want %h",
                   i, instr_o, prev_instr);
        end
      end
      pv = instr_valid_o;
      prev_instr = instr_o;
      gnt_delay = int'($urandom_range(0, 3));
      rv_lat = int'($urandom_range(0, 3));
      instr_ready_i = ($urandom_range(0, 2) != 0);
      stall_i = ($urandom_range(0, 3) == 0);
      redirect_valid_i = ($urandom_range(0, 24) == 0);
      tgt = $urandom & 32'h0000_0FFF;
      redirect_pc_i = tgt;
      if (redirect_valid_i) begin
        exp_pc = {tgt[31:2], 2'b00};
        mis_exp = (tgt[1:0] != 2'b00);
      end else begin
        mis_exp = 1'b0;
      end
    end
    redirect_valid_i = 1'b0;
    n_cmp++;
    if (ndel < 50) begin
      n_bad++;
      $display("FAIL rnd_progress: got %0d deliveries want >=50", ndel);
    end
  endtask

  initial begin
    rst_n = 1'b1;
    redirect_valid_i = 1'b0;
    redirect_pc_i = '0;
    stall_i = 1'b0;
    instr_ready_i = 1'b0;
    test_reset();
    test_first_fetch();
    test_back_to_back();
    test_stall();
    test_redirect_wait();
    test_redirect_hold();
    test_wrap();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
